// File: rtl/machine_timer_if.sv
// Register-port bundle for machine_timer: single-outstanding valid/ready request and response.
// The master side is the CPU peripheral bus; the slave side is the timer.
interface machine_timer_if #(
    parameter int unsigned ADDR_W = 5
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/machine_timer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp with prescaler, level mti_o, valid/ready register port.
// Optional MTIMER_MSIP_EN adds an MSIP register at 0x14 and the msi_o output.
module machine_timer #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned PRESCALE = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    machine_timer_if.slave bus_io,
    output logic           mti_o,
    output logic [63:0]    mtime_o
`ifdef MTIMER_MSIP_EN
    ,
    output logic           msi_o
`endif
);

    localparam int unsigned       PW          = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]     PresLast    = PW'(PRESCALE - 1);
    localparam logic [ADDR_W-1:0] AddrMtimeLo = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] AddrMtimeHi = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] AddrCmpLo   = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] AddrCmpHi   = ADDR_W'(32'h0C);
    localparam logic [ADDR_W-1:0] AddrCtrl    = ADDR_W'(32'h10);
`ifdef MTIMER_MSIP_EN
    localparam logic [ADDR_W-1:0] AddrMsip    = ADDR_W'(32'h14);
`endif

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    state_e        state_q;
    logic          ready_q, rsp_valid_q, rsp_err_q, mti_q;
    logic [31:0]   rsp_rdata_q, rd_data;
    logic [63:0]   mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic          en_q, en_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          accept, tick, dec_err, wr;
    logic          sel_mtlo, sel_mthi, sel_cmplo, sel_cmphi, sel_ctrl;
`ifdef MTIMER_MSIP_EN
    logic          msip_q, msip_d, msi_q, sel_msip;
`endif

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    assign accept = bus_io.req_valid & ready_q;
    assign tick   = en_q & (presc_q == PresLast);
    assign wr     = accept & bus_io.req_we & ~dec_err;

    always_comb begin : decode
        sel_mtlo  = 1'b0;
        sel_mthi  = 1'b0;
        sel_cmplo = 1'b0;
        sel_cmphi = 1'b0;
        sel_ctrl  = 1'b0;
`ifdef MTIMER_MSIP_EN
        sel_msip  = 1'b0;
`endif
        dec_err   = 1'b0;
        rd_data   = '0;
        if (bus_io.req_addr[1:0] != 2'b00) begin
            dec_err = 1'b1;
        end else begin
            case (bus_io.req_addr)
                AddrMtimeLo: begin sel_mtlo  = 1'b1; rd_data = mtime_q[31:0];    end
                AddrMtimeHi: begin sel_mthi  = 1'b1; rd_data = mtime_q[63:32];   end
                AddrCmpLo:   begin sel_cmplo = 1'b1; rd_data = mtimecmp_q[31:0]; end
                AddrCmpHi:   begin sel_cmphi = 1'b1; rd_data = mtimecmp_q[63:32]; end
                AddrCtrl:    begin sel_ctrl  = 1'b1; rd_data = {31'b0, en_q};    end
`ifdef MTIMER_MSIP_EN
                AddrMsip:    begin sel_msip  = 1'b1; rd_data = {31'b0, msip_q};  end
`endif
                default:     dec_err = 1'b1;
            endcase
        end
    end

    always_comb begin : next_state
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        presc_d    = presc_q;
        if (en_q) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
`ifdef MTIMER_MSIP_EN
        msip_d     = msip_q;
`endif
        // A software write to an mtime half replaces the tick for that cycle; no LO->HI carry.
        if (wr) begin
            if (sel_mtlo) begin
                mtime_d = {mtime_q[63:32],
                           merge_bytes(mtime_q[31:0], bus_io.req_wdata, bus_io.req_wstrb)};
            end
            if (sel_mthi) begin
                mtime_d = {merge_bytes(mtime_q[63:32], bus_io.req_wdata, bus_io.req_wstrb),
                           mtime_q[31:0]};
            end
            if (sel_cmplo) begin
                mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], bus_io.req_wdata,
                                               bus_io.req_wstrb);
            end
            if (sel_cmphi) begin
                mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], bus_io.req_wdata,
                                                bus_io.req_wstrb);
            end
            if (sel_ctrl && bus_io.req_wstrb[0]) begin
                en_d = bus_io.req_wdata[0];
                if (!bus_io.req_wdata[0]) begin
                    presc_d = '0;
                end
            end
`ifdef MTIMER_MSIP_EN
            if (sel_msip && bus_io.req_wstrb[0]) begin
                msip_d = bus_io.req_wdata[0];
            end
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mti_q       <= 1'b0;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            en_q        <= 1'b0;
            presc_q     <= '0;
`ifdef MTIMER_MSIP_EN
            msip_q      <= 1'b0;
            msi_q       <= 1'b0;
`endif
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            presc_q    <= presc_d;
            mti_q      <= (mtime_q >= mtimecmp_q);
`ifdef MTIMER_MSIP_EN
            msip_q     <= msip_d;
            msi_q      <= msip_q;
`endif
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q     <= StResp;
                        ready_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= dec_err;
                        rsp_rdata_q <= bus_io.req_we ? '0 : rd_data;
                    end
                end
                StResp: begin
                    if (bus_io.rsp_ready) begin
                        state_q     <= StIdle;
                        ready_q     <= 1'b1;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_io.req_ready = ready_q;
    assign bus_io.rsp_valid = rsp_valid_q;
    assign bus_io.rsp_rdata = rsp_rdata_q;
    assign bus_io.rsp_err   = rsp_err_q;
    assign mti_o            = mti_q;
    assign mtime_o          = mtime_q;
`ifdef MTIMER_MSIP_EN
    assign msi_o            = msi_q;
`endif

endmodule

// File: tb/tb_machine_timer.sv
// Self-checking bench for machine_timer: directed scenarios plus randomized register traffic
// checked against a cycle-level behavioural model of the timer register map.
module tb_machine_timer;
    localparam int unsigned PRESCALE = 4;
`ifdef MTIMER_MSIP_EN
    localparam logic [4:0] MaxAddr = 5'h14;
`else
    localparam logic [4:0] MaxAddr = 5'h10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mti;
    logic [63:0] mtime;
`ifdef MTIMER_MSIP_EN
    logic        msi;
`endif

    machine_timer_if #(.ADDR_W(5)) bus ();

    machine_timer #(.ADDR_W(5), .PRESCALE(PRESCALE)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .bus_io  (bus),
        .mti_o   (mti),
        .mtime_o (mtime)
`ifdef MTIMER_MSIP_EN
        ,
        .msi_o   (msi)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [63:0] m_mtime = '0, m_cmp = '1;
    logic        m_en = 1'b0, m_mti = 1'b0, m_busy = 1'b0, m_msip = 1'b0, m_msi = 1'b0;
    int unsigned m_phase = 0;
    logic [31:0] m_rsp_rdata = '0;
    logic        m_rsp_err = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    // Advance one clock and apply the model's view of what happens at that edge.
    task automatic cycle();
        logic c_rst, acc, c_we, c_rr, tick, aerr;
        logic [4:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [63:0] mt0, cmp0;
        logic        en0, msip0;
        c_rst = rst; c_we = bus.req_we; c_rr = bus.rsp_ready;
        a = bus.req_addr; d = bus.req_wdata; s = bus.req_wstrb;
        acc = bus.req_valid && !m_busy;
        mt0 = m_mtime; cmp0 = m_cmp; en0 = m_en; msip0 = m_msip;
        @(posedge clk);
        if (c_rst) begin
            m_mtime = '0; m_cmp = '1; m_en = 1'b0; m_phase = 0; m_mti = 1'b0;
            m_busy = 1'b0; m_msip = 1'b0; m_msi = 1'b0;
        end else begin
            m_mti = (mt0 >= cmp0);
            m_msi = msip0;
            tick = 1'b0;
            if (en0) begin
                m_phase++;
                if (m_phase == PRESCALE) begin m_phase = 0; tick = 1'b1; end
            end
            if (tick) m_mtime = mt0 + 64'd1;
            if (m_busy && c_rr) m_busy = 1'b0;
            if (acc) begin
                m_busy = 1'b1;
                aerr = (a[1:0] != 2'b00) || (a > MaxAddr);
                m_rsp_err = aerr;
                m_rsp_rdata = '0;
                if (!aerr && !c_we) begin
                    case (a)
                        5'h00: m_rsp_rdata = mt0[31:0];
                        5'h04: m_rsp_rdata = mt0[63:32];
                        5'h08: m_rsp_rdata = cmp0[31:0];
                        5'h0C: m_rsp_rdata = cmp0[63:32];
                        5'h10: m_rsp_rdata = {31'b0, en0};
                        default: m_rsp_rdata = {31'b0, msip0};
                    endcase
                end
                if (!aerr && c_we) begin
                    case (a)
                        5'h00: m_mtime = {mt0[63:32], merge(mt0[31:0], d, s)};
                        5'h04: m_mtime = {merge(mt0[63:32], d, s), mt0[31:0]};
                        5'h08: m_cmp[31:0] = merge(cmp0[31:0], d, s);
                        5'h0C: m_cmp[63:32] = merge(cmp0[63:32], d, s);
                        5'h10: if (s[0]) begin
                            m_en = d[0];
                            if (!d[0]) m_phase = 0;
                        end
                        default: if (s[0]) m_msip = d[0];
                    endcase
                end
            end
        end
        #1;
    endtask

    task automatic xact(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int hold,
                        output logic o_valid, output logic [31:0] o_rdata, output logic o_err,
                        output logic o_stable, output logic o_mti);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
        bus.req_wdata = wdata; bus.req_wstrb = wstrb; bus.rsp_ready = (hold == 0);
        cycle();
        bus.req_valid = 1'b0;
        o_valid = bus.rsp_valid; o_rdata = bus.rsp_rdata; o_err = bus.rsp_err; o_mti = mti;
        o_stable = (bus.req_ready === 1'b0);
        for (int i = 0; i < hold; i++) begin
            cycle();
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== o_rdata || bus.rsp_err !== o_err ||
                bus.req_ready !== 1'b0) o_stable = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        cycle();
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        logic v, e, s, m;
        logic [31:0] r;
        xact(1'b1, addr, data, 4'hF, 0, v, r, e, s, m);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic v, e, s, m;
        logic [31:0] r;
        rst = 1'b1;
        repeat (3) cycle();
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.req_ready); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid); end
        total++; if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", bus.rsp_rdata); end
        total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.rsp_err); end
        rst = 1'b0;
        repeat (100) cycle();
        total++; if (mti !== 1'b0) begin bad++; $display("FAIL idle_mti got=%b want=0", mti); end
        total++; if (mtime !== 64'h0) begin bad++; $display("FAIL idle_mtime got=%h want=0", mtime); end
        xact(1'b0, 5'h0C, 32'h0, 4'h0, 0, v, r, e, s, m);
        total++; if (v !== 1'b1) begin bad++; $display("FAIL cmphi_valid got=%b want=1", v); end
        total++; if (r !== 32'hFFFF_FFFF || e !== 1'b0) begin bad++; $display("FAIL cmphi_read got=%h/%b want=ffffffff/0", r, e); end
    endtask

    task automatic test_prescale();
        logic v, e, s, m;
        logic [31:0] r;
        do_reset();
        write_reg(5'h10, 32'h1);
        repeat (40) cycle();
        total++; if (mtime !== m_mtime) begin bad++; $display("FAIL presc_mtime got=%0d want=%0d", mtime, m_mtime); end
        total++; if (mtime < 64'd9 || mtime > 64'd11) begin bad++; $display("FAIL presc_range got=%0d want=10+/-1", mtime); end
        write_reg(5'h10, 32'h0);
        repeat (10) cycle();
        total++; if (mtime !== m_mtime) begin bad++; $display("FAIL frozen_mtime got=%0d want=%0d", mtime, m_mtime); end
        xact(1'b0, 5'h10, 32'h0, 4'h0, 0, v, r, e, s, m);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL ctrl_read got=%h want=0", r); end
        write_reg(5'h10, 32'h1);
        for (int i = 0; i < 12; i++) begin
            cycle();
            total++; if (mtime !== m_mtime) begin bad++; $display("FAIL restart_mtime[%0d] got=%0d want=%0d", i, mtime, m_mtime); end
        end
    endtask

    task automatic test_compare();
        logic v, e, s, m, found;
        logic [31:0] r;
        do_reset();
        write_reg(5'h0C, 32'h0);
        write_reg(5'h08, 32'd20);
        write_reg(5'h10, 32'h1);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle();
            total++; if (mti !== m_mti) begin bad++; $display("FAIL cmp_mti[%0d] got=%b want=%b", i, mti, m_mti); end
            if (mtime == 64'd20) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL cmp_reach20 got=timeout want=mtime 20");
        end else begin
            total++; if (mti !== 1'b0) begin bad++; $display("FAIL cmp_pre_rise got=%b want=0", mti); end
            cycle();
            total++; if (mti !== 1'b1) begin bad++; $display("FAIL cmp_rise got=%b want=1", mti); end
        end
        xact(1'b1, 5'h08, 32'd100, 4'hF, 0, v, r, e, s, m);
        total++; if (m !== 1'b1) begin bad++; $display("FAIL cmp_fall_lag got=%b want=1", m); end
        total++; if (mti !== 1'b0) begin bad++; $display("FAIL cmp_fall got=%b want=0", mti); end
    endtask

    task automatic test_wrap();
        int seq;
        do_reset();
        write_reg(5'h0C, 32'h0);
        write_reg(5'h08, 32'd5);
        write_reg(5'h00, 32'hFFFF_FFFF);
        write_reg(5'h04, 32'hFFFF_FFFF);
        write_reg(5'h10, 32'h1);
        seq = 0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            total++; if (mti !== m_mti || mtime !== m_mtime) begin bad++; $display("FAIL wrap[%0d] got=%b/%h want=%b/%h", i, mti, mtime, m_mti, m_mtime); end
            if ((seq == 0 && mti) || (seq == 1 && !mti) || (seq == 2 && mti)) seq++;
        end
        total++; if (seq != 3) begin bad++; $display("FAIL wrap_toggle got=%0d want=3", seq); end
        total++; if (mtime >= 64'd100) begin bad++; $display("FAIL wrap_value got=%h want=<100", mtime); end
    endtask

    task automatic test_errors();
        logic v, e, s, m;
        logic [31:0] r;
        do_reset();
        xact(1'b0, 5'h02, 32'h0, 4'h0, 5, v, r, e, s, m);
        total++; if (v !== 1'b1 || e !== 1'b1 || r !== 32'h0) begin bad++; $display("FAIL err_02 got=%b/%b/%h want=1/1/0", v, e, r); end
        total++; if (s !== 1'b1) begin bad++; $display("FAIL err_hold_stable got=%b want=1", s); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL err_ready_back got=%b want=1", bus.req_ready); end
        xact(1'b0, 5'h18, 32'h0, 4'h0, 0, v, r, e, s, m);
        total++; if (e !== 1'b1 || r !== 32'h0) begin bad++; $display("FAIL err_18 got=%b/%h want=1/0", e, r); end
        xact(1'b1, 5'h09, $urandom, 4'hF, 1, v, r, e, s, m);
        total++; if (e !== 1'b1 || r !== 32'h0) begin bad++; $display("FAIL err_wr09 got=%b/%h want=1/0", e, r); end
        xact(1'b0, 5'h08, 32'h0, 4'h0, 0, v, r, e, s, m);
        total++; if (r !== 32'hFFFF_FFFF || r !== m_rsp_rdata) begin bad++; $display("FAIL err_nochange got=%h want=ffffffff", r); end
`ifdef MTIMER_MSIP_EN
        write_reg(5'h14, 32'h1);
        total++; if (msi !== 1'b1 || msi !== m_msi) begin bad++; $display("FAIL msi got=%b want=1", msi); end
        xact(1'b0, 5'h14, 32'h0, 4'h0, 0, v, r, e, s, m);
        total++; if (r !== 32'h1 || e !== 1'b0) begin bad++; $display("FAIL msip_read got=%h/%b want=1/0", r, e); end
`else
        xact(1'b0, 5'h14, 32'h0, 4'h0, 0, v, r, e, s, m);
        total++; if (e !== 1'b1 || r !== 32'h0) begin bad++; $display("FAIL err_14 got=%b/%h want=1/0", e, r); end
`endif
    endtask

    task automatic test_wstrb();
        logic v, e, s, m;
        logic [31:0] r;
        do_reset();
        write_reg(5'h00, 32'h1234_5678);
        xact(1'b1, 5'h00, {$urandom_range(0, 32'h00FF_FFFF) , 8'hAB} , 4'b0001, 0, v, r, e, s, m);
        total++; if (r !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL wstrb_wr_rsp got=%h/%b want=0/0", r, e); end
        xact(1'b0, 5'h00, 32'h0, 4'h0, 0, v, r, e, s, m);
        total++; if (r !== 32'h1234_56AB || r !== m_rsp_rdata) begin bad++; $display("FAIL wstrb_lo got=%h want=123456ab", r); end
        xact(1'b0, 5'h04, 32'h0, 4'h0, 0, v, r, e, s, m);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL wstrb_hi got=%h want=0", r); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 5'h0C; bus.rsp_ready = 1'b0;
        cycle();
        bus.req_valid = 1'b0;
        total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b want=1", bus.rsp_valid); end
        rst = 1'b1;
        cycle();
        total++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin bad++; $display("FAIL mid_reset got=%b/%b want=0/1", bus.rsp_valid, bus.req_ready); end
        total++; if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL mid_rdata got=%h want=0", bus.rsp_rdata); end
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        cycle();
    endtask

    task automatic test_random();
        logic [4:0]  pool [9];
        logic [4:0]  a;
        logic        we, v, e, s, m;
        logic [31:0] d, r;
        int          idle;
        pool = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h02, 5'h18, 5'h1F};
        do_reset();
        for (int n = 0; n < 150; n++) begin
            a  = pool[$urandom_range(0, 8)];
            we = 1'($urandom_range(0, 1));
            d  = $urandom;
            if (a == 5'h04 || a == 5'h0C) d = $urandom_range(0, 1);
            xact(we, a, d, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), v, r, e, s, m);
            total++; if (v !== 1'b1 || s !== 1'b1) begin bad++; $display("FAIL rnd_hs[%0d] got=%b/%b want=1/1", n, v, s); end
            total++; if (r !== m_rsp_rdata || e !== m_rsp_err) begin bad++; $display("FAIL rnd_rsp[%0d] a=%h got=%h/%b want=%h/%b", n, a, r, e, m_rsp_rdata, m_rsp_err); end
            idle = int'($urandom_range(0, 2));
            for (int k = 0; k < idle; k++) cycle();
            total++; if (mtime !== m_mtime || mti !== m_mti) begin bad++; $display("FAIL rnd_timer[%0d] got=%h/%b want=%h/%b", n, mtime, mti, m_mtime, m_mti); end
`ifdef MTIMER_MSIP_EN
            total++; if (msi !== m_msi) begin bad++; $display("FAIL rnd_msi[%0d] got=%b want=%b", n, msi, m_msi); end
`endif
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_wstrb = '0; bus.rsp_ready = 1'b0;
        test_reset();
        test_prescale();
        test_compare();
        test_wrap();
        test_errors();
        test_wstrb();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
